// File: rtl/cont_sched_pkg.sv
// cont_sched_pkg: shared definitions for the counter scheduler.
//   CONT_SCHED_WIDTH : default width of counter values and targets
//   state_t          : scheduler FSM states (IDLE, RUN, DONE)
package cont_sched_pkg;

  localparam int unsigned CONT_SCHED_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   valid[1:0]  : request lines
//   last_owner  : index of the previously granted requester
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
// With both requesters valid, the one that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[0] && (!valid[1] || last_owner)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/cont_sched.sv
// cont_sched: two-requester scheduler that drives an external up/down
// counter to a requested target along the shortest wrap-around path.
//   clk, reset                 : clock, synchronous active-high reset
//   reqN_valid / reqN_target   : requester N job request and target value
//   reqN_ready                 : request accepted this cycle (IDLE only)
//   reqN_done                  : one-cycle pulse when requester N's job ends
//   abort                      : terminate the running job (RUN only)
//   cnt_value                  : current count fed back from the counter
//   cnt_en / cnt_up_down       : counter step enable and direction (1 = up)
//   busy                       : high whenever not IDLE
//   owner                      : requester of the current / latest job
//   aborted                    : qualifies reqN_done; job ended by abort
module cont_sched
  import cont_sched_pkg::*;
#(
  parameter int unsigned WIDTH = CONT_SCHED_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_target,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_target,
  output logic             req1_ready,
  output logic             req1_done,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_up_down,
  output logic             busy,
  output logic             owner,
  output logic             aborted
);

  // Distances up to and including half the range go up; the tie goes up.
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] diff;
  logic             last_owner;
  logic [1:0]       grant;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner),
    .grant      (grant)
  );

  assign diff = target - cnt_value;

  // Outputs are gated by reset so a reset cycle in mid-job neither steps
  // the counter nor pulses done, even though state is still RUN/DONE.
  always_comb begin
    req0_ready  = (state == IDLE) && !reset && grant[0];
    req1_ready  = (state == IDLE) && !reset && grant[1];
    cnt_en      = (state == RUN) && !reset && !abort && (diff != '0);
    cnt_up_down = cnt_en && (diff <= HALF);
    req0_done   = (state == DONE) && !reset && !owner;
    req1_done   = (state == DONE) && !reset && owner;
    busy        = (state != IDLE) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      aborted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            target     <= grant[1] ? req1_target : req0_target;
            owner      <= grant[1];
            last_owner <= grant[1];
            aborted    <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (diff == '0) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cont_sched.sv
module tb_cont_sched;

  typedef struct packed {
    logic        which;
    logic        own;
    logic        ab;
    logic [31:0] lat;
    logic [7:0]  cnt;
    logic [15:0] up;
    logic [15:0] dn;
  } job_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, abort = 1'b0;
  logic [7:0] req0_target = '0, req1_target = '0;
  logic       req0_ready, req1_ready, req0_done, req1_done;
  logic       cnt_en, cnt_up_down, busy, owner, aborted;
  logic [7:0] cnt;
  logic       ld = 1'b1;
  logic [7:0] ld_val = '0;

  int checks = 0;
  int failures = 0;

  job_t exp_q[$];
  job_t obs_q[$];
  int   exp_rd = 0, obs_rd = 0;

  int unsigned cyc = 0, xfer_cyc = 0;
  logic [15:0] up_n = '0, dn_n = '0;

  cont_sched #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_target (req0_target),
    .req0_ready  (req0_ready),
    .req0_done   (req0_done),
    .req1_valid  (req1_valid),
    .req1_target (req1_target),
    .req1_ready  (req1_ready),
    .req1_done   (req1_done),
    .abort       (abort),
    .cnt_value   (cnt),
    .cnt_en      (cnt_en),
    .cnt_up_down (cnt_up_down),
    .busy        (busy),
    .owner       (owner),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  // External up/down counter with a preload port.
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (cnt_en) cnt <= cnt_up_down ? cnt + 8'd1 : cnt - 8'd1;
  end

  // Monitor: records transfer time, step directions and each done pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      xfer_cyc <= cyc;
      up_n <= '0;
      dn_n <= '0;
    end else if (cnt_en) begin
      if (cnt_up_down) up_n <= up_n + 16'd1;
      else dn_n <= dn_n + 16'd1;
    end
    if (req0_done || req1_done)
      obs_q.push_back('{which: req1_done, own: owner, ab: aborted,
                        lat: cyc - xfer_cyc, cnt: cnt, up: up_n, dn: dn_n});
  end

  task automatic load(input logic [7:0] v);
    @(posedge clk); #1;
    ld = 1'b1; ld_val = v;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Returns one time unit after the transfer edge (first RUN cycle).
  task automatic start(input bit r, input logic [7:0] t, output bit ok);
    @(posedge clk); #1;
    if (r) begin req1_valid = 1'b1; req1_target = t; end
    else begin req0_valid = 1'b1; req0_target = t; end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (r ? req1_ready : req0_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() > obs_rd) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, req0_done, req1_done, cnt_en, cnt_up_down, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {req0_ready, req1_ready, req0_done, req1_done, cnt_en, cnt_up_down, busy});
    end
    checks++;
    if ({owner, aborted} !== 2'b00) begin
      failures++;
      $display("FAIL reset_owner_aborted got=%b want=00", {owner, aborted});
    end
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; ld = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, busy, cnt_en} !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b want=0000", {req0_ready, req1_ready, busy, cnt_en});
    end
  endtask

  // Single-job scenario: preload, issue, push expectation, compare at done.
  task automatic test_job(input string name, input logic [7:0] c0, input bit r,
                          input logic [7:0] t, input int unsigned lat,
                          input int unsigned up, input int unsigned dn);
    bit ok;
    job_t o, e;
    load(c0);
    start(r, t, ok);
    exp_q.push_back('{which: r, own: r, ab: 1'b0, lat: lat, cnt: t,
                      up: up[15:0], dn: dn[15:0]});
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_accept timeout", name); end
    wait_obs(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL %s_done timeout", name);
    end else begin
      o = obs_q[obs_rd]; e = exp_q[exp_rd];
      obs_rd++; exp_rd++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s got which=%0d own=%0d ab=%0d lat=%0d cnt=%0d up=%0d dn=%0d want which=%0d own=%0d ab=%0d lat=%0d cnt=%0d up=%0d dn=%0d",
                 name, o.which, o.own, o.ab, o.lat, o.cnt, o.up, o.dn,
                 e.which, e.own, e.ab, e.lat, e.cnt, e.up, e.dn);
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    job_t o, e;
    load(8'd0);
    start(1'b0, 8'd10, ok);
    exp_q.push_back('{which: 1'b0, own: 1'b0, ab: 1'b1, lat: 32'd4, cnt: 8'd2,
                      up: 16'd2, dn: 16'd0});
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_accept timeout"); end
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0) begin
      failures++; $display("FAIL abort_cnt_en got=%b want=0", cnt_en);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    wait_obs(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL abort_done timeout");
    end else begin
      o = obs_q[obs_rd]; e = exp_q[exp_rd];
      obs_rd++; exp_rd++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_job got ab=%0d lat=%0d cnt=%0d up=%0d want ab=%0d lat=%0d cnt=%0d up=%0d",
                 o.ab, o.lat, o.cnt, o.up, e.ab, e.lat, e.cnt, e.up);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt, aborted, busy} !== {8'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL abort_frozen got cnt=%0d aborted=%b busy=%b want cnt=2 aborted=1 busy=0",
               cnt, aborted, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    load(8'd0);
    start(1'b1, 8'd50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_accept timeout"); end
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checks++;
    if ({cnt_en, busy} !== 2'b00) begin
      failures++; $display("FAIL midrst_outputs got=%b want=00", {cnt_en, busy});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (obs_q.size() !== obs_rd || busy !== 1'b0 || cnt !== 8'd3) begin
      failures++;
      $display("FAIL midrst_no_done got dones=%0d busy=%b cnt=%0d want dones=0 busy=0 cnt=3",
               obs_q.size() - obs_rd, busy, cnt);
    end
  endtask

  task automatic test_back_to_back;
    bit got, ok, w;
    job_t o, e;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load(8'd20);
    req0_target = 8'd20; req1_target = 8'd22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_q.push_back('{which: 1'b0, own: 1'b0, ab: 1'b0, lat: 32'd2, cnt: 8'd20, up: 16'd0, dn: 16'd0});
    exp_q.push_back('{which: 1'b1, own: 1'b1, ab: 1'b0, lat: 32'd4, cnt: 8'd22, up: 16'd2, dn: 16'd0});
    exp_q.push_back('{which: 1'b0, own: 1'b0, ab: 1'b0, lat: 32'd4, cnt: 8'd20, up: 16'd0, dn: 16'd2});
    exp_q.push_back('{which: 1'b1, own: 1'b1, ab: 1'b0, lat: 32'd4, cnt: 8'd22, up: 16'd2, dn: 16'd0});
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; w = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          w = req1_ready;
          checks++;
          if ({req0_ready, req1_ready} !== (k % 2 == 1 ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL rr_grant_%0d got r0=%b r1=%b want winner=%0d", k, req0_ready, req1_ready, k % 2);
          end
        end
        @(posedge clk); #1;
        if (got && k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL rr_grant_%0d timeout", k);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rr_job_%0d timeout", k);
      end else begin
        o = obs_q[obs_rd]; e = exp_q[exp_rd];
        obs_rd++; exp_rd++;
        if (o !== e) begin
          failures++;
          $display("FAIL rr_job_%0d got which=%0d lat=%0d cnt=%0d up=%0d dn=%0d want which=%0d lat=%0d cnt=%0d up=%0d dn=%0d",
                   k, o.which, o.lat, o.cnt, o.up, o.dn, e.which, e.lat, e.cnt, e.up, e.dn);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_job("basic_up",   8'd10,  1'b0, 8'd15,  7,   5,   0);
    test_job("wrap_up",    8'd250, 1'b1, 8'd3,   11,  9,   0);
    test_job("tie_up",     8'd0,   1'b0, 8'd128, 130, 128, 0);
    test_job("past_half",  8'd0,   1'b0, 8'd129, 129, 0,   127);
    test_abort;
    test_job("equal",      8'd55,  1'b0, 8'd55,  2,   0,   0);
    test_reset_mid_run;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
